// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with 16x oversampled receiver.
//
// Parameters:
//   CLK_FREQ  system clock in Hz
//   BAUD      line rate in bit/s
//   DATA_BITS payload bits per frame (5..8)
//   PARITY    0 none, 1 even, 2 odd
//   STOP_BITS 1 or 2
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   tx_en, rx_en   transmitter / receiver enables
//   begin_flag     start-transmit request, sampled every clk
//   tx_data        word to send
//   rx             asynchronous serial input
//   tx             serial output
//   rx_data        last received word
//   busy_flag      transmitter busy
//   receive_flag   one-clk pulse when rx_data / error flags update
//   frame_err      first stop bit of the last frame was low
//   parity_err     parity mismatch in the last frame (0 when PARITY=0)
//
// Optional build macro UART_LOOPBACK_EN adds input 'loopback': when high the
// receiver listens to the internal transmitter (no synchroniser) and the tx
// pin is held idle-high.

module uart_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 rx_en,
  input  logic                 begin_flag,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 busy_flag,
  output logic                 receive_flag,
  output logic                 frame_err,
  output logic                 parity_err
);

  // Divider rounded to the nearest integer so the baud error is minimised.
  localparam int DIV        = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STOP_TICKS = 16 * STOP_BITS;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       HAS_PAR  = (PARITY != 0);
  localparam logic       PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  // Shared 16x oversampling tick, free-running while out of reset.
  logic [DIV_W-1:0] div_cnt;
  logic             tick16;

  assign tick16 = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick16) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_t            tx_state, tx_state_nxt;
  logic [4:0]           tx_tcnt, tx_tcnt_nxt;
  logic [2:0]           tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                 tx_par, tx_par_nxt;
  logic                 tx_q, tx_q_nxt;
  logic                 busy_q, busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tcnt  <= tx_tcnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_q     <= tx_q_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // The line level is computed for the state being entered, so tx is a
  // registered, glitch-free output that changes on the same edge as the state.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_tcnt_nxt  = tx_tcnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_q_nxt     = tx_q;
    case (tx_state)
      TX_IDLE: begin
        tx_q_nxt = 1'b1;
        if (tx_en && begin_flag && !busy_q) begin
          tx_state_nxt = TX_START;
          tx_shift_nxt = tx_data;
          tx_par_nxt   = (^tx_data) ^ PAR_ODD;
          tx_tcnt_nxt  = '0;
          tx_bit_nxt   = '0;
          tx_q_nxt     = 1'b0;
        end
      end
      TX_START: begin
        if (tick16) begin
          if (tx_tcnt == 5'd15) begin
            tx_state_nxt = TX_DATA;
            tx_tcnt_nxt  = '0;
            tx_q_nxt     = tx_shift[0];
          end else begin
            tx_tcnt_nxt = tx_tcnt + 5'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick16) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt_nxt = '0;
            if (tx_bit == LAST_BIT) begin
              if (HAS_PAR) begin
                tx_state_nxt = TX_PAR;
                tx_q_nxt     = tx_par;
              end else begin
                tx_state_nxt = TX_STOP;
                tx_q_nxt     = 1'b1;
              end
            end else begin
              tx_bit_nxt   = tx_bit + 3'd1;
              tx_shift_nxt = tx_shift >> 1;
              tx_q_nxt     = tx_shift[1];
            end
          end else begin
            tx_tcnt_nxt = tx_tcnt + 5'd1;
          end
        end
      end
      TX_PAR: begin
        if (tick16) begin
          if (tx_tcnt == 5'd15) begin
            tx_state_nxt = TX_STOP;
            tx_tcnt_nxt  = '0;
            tx_q_nxt     = 1'b1;
          end else begin
            tx_tcnt_nxt = tx_tcnt + 5'd1;
          end
        end
      end
      TX_STOP: begin
        tx_q_nxt = 1'b1;
        if (tick16) begin
          if (tx_tcnt == 5'(STOP_TICKS - 1)) begin
            tx_state_nxt = TX_IDLE;
            tx_tcnt_nxt  = '0;
          end else begin
            tx_tcnt_nxt = tx_tcnt + 5'd1;
          end
        end
      end
      default: begin
        tx_state_nxt = TX_IDLE;
        tx_q_nxt     = 1'b1;
      end
    endcase
    busy_nxt = (tx_state_nxt != TX_IDLE);
  end

  assign busy_flag = busy_q;

  // ---------------- Receiver ----------------
  logic rx_s1, rx_s2, rx_prev, rx_in;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_q : rx_s2;
  assign tx    = loopback ? 1'b1 : tx_q;
`else
  assign rx_in = rx_s2;
  assign tx    = tx_q;
`endif

  // Two-flop synchroniser plus one history flop for start-edge detection;
  // all preset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_in;
    end
  end

  rx_state_t            rx_state, rx_state_nxt;
  logic [3:0]           rx_tcnt, rx_tcnt_nxt;
  logic [2:0]           rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                 rx_par, rx_par_nxt;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_nxt;
  logic                 fe_q, fe_nxt, pe_q, pe_nxt, flag_q, flag_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_tcnt   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      rx_data_q <= '0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      rx_state  <= rx_state_nxt;
      rx_tcnt   <= rx_tcnt_nxt;
      rx_bit    <= rx_bit_nxt;
      rx_shift  <= rx_shift_nxt;
      rx_par    <= rx_par_nxt;
      rx_data_q <= rx_data_nxt;
      fe_q      <= fe_nxt;
      pe_q      <= pe_nxt;
      flag_q    <= flag_nxt;
    end
  end

  // The tick count restarts at the start edge, so 8 ticks lands mid start
  // bit and every further 16 ticks lands mid bit. The FSM returns to IDLE at
  // the centre of the first stop bit so a back-to-back start edge is seen.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_tcnt_nxt  = rx_tcnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_par_nxt   = rx_par;
    rx_data_nxt  = rx_data_q;
    fe_nxt       = fe_q;
    pe_nxt       = pe_q;
    flag_nxt     = 1'b0;
    if (!rx_en) begin
      rx_state_nxt = RX_IDLE;
      rx_tcnt_nxt  = '0;
      rx_bit_nxt   = '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_state_nxt = RX_START;
            rx_tcnt_nxt  = '0;
            rx_bit_nxt   = '0;
          end
        end
        RX_START: begin
          if (tick16) begin
            if (rx_tcnt == 4'd7) begin
              rx_tcnt_nxt  = '0;
              rx_state_nxt = rx_in ? RX_IDLE : RX_DATA;
            end else begin
              rx_tcnt_nxt = rx_tcnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick16) begin
            if (rx_tcnt == 4'd15) begin
              rx_tcnt_nxt  = '0;
              rx_shift_nxt = {rx_in, rx_shift[DATA_BITS-1:1]};
              if (rx_bit == LAST_BIT) begin
                rx_state_nxt = HAS_PAR ? RX_PAR : RX_STOP;
              end else begin
                rx_bit_nxt = rx_bit + 3'd1;
              end
            end else begin
              rx_tcnt_nxt = rx_tcnt + 4'd1;
            end
          end
        end
        RX_PAR: begin
          if (tick16) begin
            if (rx_tcnt == 4'd15) begin
              rx_tcnt_nxt  = '0;
              rx_par_nxt   = rx_in;
              rx_state_nxt = RX_STOP;
            end else begin
              rx_tcnt_nxt = rx_tcnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick16) begin
            if (rx_tcnt == 4'd15) begin
              rx_tcnt_nxt  = '0;
              rx_state_nxt = RX_IDLE;
              rx_data_nxt  = rx_shift;
              fe_nxt       = !rx_in;
              pe_nxt       = HAS_PAR && (rx_par != ((^rx_shift) ^ PAR_ODD));
              flag_nxt     = 1'b1;
            end else begin
              rx_tcnt_nxt = rx_tcnt + 4'd1;
            end
          end
        end
        default: begin
          rx_state_nxt = RX_IDLE;
          rx_tcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign frame_err    = fe_q;
  assign parity_err   = pe_q;
  assign receive_flag = flag_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: bench for uart_core. Instance dut0 uses the default 8N1
// configuration, dut1 uses even parity; with UART_LOOPBACK_EN defined a third
// 7-bit, 2-stop-bit instance runs in loopback.
module tb_uart_core;

  localparam int BIT = 432;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       rx_en = 1'b0;
  logic       begin_flag = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       tx0, tx1, busy0, busy1, flag0, flag1, fe0, fe1, pe0, pe1;
  logic [7:0] rxd0, rxd1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rx_exp_t;

  rx_exp_t    q0[$];
  rx_exp_t    q1[$];
  logic [7:0] last_d[2];
  logic       last_fe[2];
  logic       last_pe[2];

  uart_core dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .rx_en(rx_en),
    .begin_flag(begin_flag), .tx_data(tx_data), .rx(rx0),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx0), .rx_data(rxd0), .busy_flag(busy0), .receive_flag(flag0),
    .frame_err(fe0), .parity_err(pe0)
  );

  uart_core #(.PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .rx_en(rx_en),
    .begin_flag(1'b0), .tx_data(8'h00), .rx(rx1),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx1), .rx_data(rxd1), .busy_flag(busy1), .receive_flag(flag1),
    .frame_err(fe1), .parity_err(pe1)
  );

`ifdef UART_LOOPBACK_EN
  logic       begin2 = 1'b0;
  logic [6:0] tx_data2 = 7'h00;
  logic       tx2, busy2, flag2, fe2, pe2;
  logic [6:0] rxd2;

  uart_core #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .rx_en(rx_en),
    .begin_flag(begin2), .tx_data(tx_data2), .rx(1'b1), .loopback(1'b1),
    .tx(tx2), .rx_data(rxd2), .busy_flag(busy2), .receive_flag(flag2),
    .frame_err(fe2), .parity_err(pe2)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before completion, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int val, input int lo, input int hi);
    n_cmp++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  function automatic logic correctPar(input logic [7:0] d, input int mode);
    return (^d) ^ (mode == 2);
  endfunction

  // Model: every completed frame must raise exactly one flag carrying the
  // word and error flags predicted at send time; otherwise outputs hold.
  task automatic compareRx(input int idx, input logic flag, input logic [7:0] d,
                           input logic fe, input logic pe);
    rx_exp_t e;
    int      pending;
    pending = (idx == 0) ? q0.size() : q1.size();
    if (flag) begin
      if (pending == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL rx%0d_unexpected_flag: got receive_flag=1 (data %0h), expected 0", idx, d);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        checkOutput($sformatf("rx%0d_frame", idx), {22'd0, d, fe, pe}, {22'd0, e.d, e.fe, e.pe});
        last_d[idx]  = e.d;
        last_fe[idx] = e.fe;
        last_pe[idx] = e.pe;
      end
    end else begin
      checkOutput($sformatf("rx%0d_hold", idx), {22'd0, d, fe, pe},
                  {22'd0, last_d[idx], last_fe[idx], last_pe[idx]});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        last_d[i]  = 8'h00;
        last_fe[i] = 1'b0;
        last_pe[i] = 1'b0;
      end
      checkOutput("reset_state0", {19'd0, tx0, busy0, flag0, fe0, pe0, rxd0}, {19'd0, 5'b10000, 8'h00});
      checkOutput("reset_state1", {19'd0, tx1, busy1, flag1, fe1, pe1, rxd1}, {19'd0, 5'b10000, 8'h00});
    end else begin
      compareRx(0, flag0, rxd0, fe0, pe0);
      compareRx(1, flag1, rxd1, fe1, pe1);
      checkOutput("dut1_tx_idle", {30'd0, tx1, busy1}, 32'd2);
    end
  end

  task automatic driveRx(input int idx, input logic v, input int n);
    @(negedge clk);
    if (idx == 0) rx0 = v;
    else          rx1 = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // Drives one full serial frame into the chosen instance and records what
  // the receiver must report for it.
  task automatic applyStimulus(input int idx, input logic [7:0] d, input int mode,
                               input logic bad_par, input logic stop_low);
    rx_exp_t e;
    e.d  = d;
    e.fe = stop_low;
    e.pe = (mode != 0) && bad_par;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
    driveRx(idx, 1'b0, BIT);
    for (int i = 0; i < 8; i++) driveRx(idx, d[i], BIT);
    if (mode != 0) driveRx(idx, correctPar(d, mode) ^ bad_par, BIT);
    driveRx(idx, !stop_low, BIT);
    driveRx(idx, 1'b1, BIT);
    repeat (50) @(negedge clk);
    checkOutput($sformatf("rx%0d_pending", idx), (idx == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic sendTx(input logic [7:0] d, input bit drop_en, input bit poke);
    int c1, crise, cfall;
    @(negedge clk);
    tx_data    = d;
    begin_flag = 1'b1;
    @(negedge clk);
    begin_flag = 1'b0;
    c1 = cyc;
    checkOutput("tx_start_low", {31'd0, tx0}, 0);
    checkOutput("busy_rise", {31'd0, busy0}, 1);
    for (int i = 0; i < 1000 && tx0 == 1'b0; i++) @(negedge clk);
    crise = cyc;
    checkRange("start_bit_len", crise - c1, 405, 432);
    repeat (BIT / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("tx_bit%0d", k), {31'd0, tx0}, {31'd0, d[k]});
      checkOutput("busy_mid", {31'd0, busy0}, 1);
      if (drop_en && k == 2) tx_en = 1'b0;
      if (poke && k == 3) begin
        begin_flag = 1'b1;
        tx_data    = ~d;
        @(negedge clk);
        begin_flag = 1'b0;
        repeat (BIT - 1) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    checkOutput("tx_stop_bit", {30'd0, tx0, busy0}, 32'd3);
    for (int i = 0; i < 1000 && busy0 == 1'b1; i++) @(negedge clk);
    cfall = cyc;
    checkRange("busy_len", cfall - c1, 4293, 4320);
    checkOutput("busy_len_exact", cfall - c1, (crise - c1) + 9 * BIT);
    checkOutput("tx_idle_after", {31'd0, tx0}, 1);
    if (drop_en) begin
      @(negedge clk);
      begin_flag = 1'b1;
      @(negedge clk);
      begin_flag = 1'b0;
      repeat (50) @(negedge clk);
      checkOutput("start_blocked", {30'd0, tx0, busy0}, 32'd2);
      tx_en = 1'b1;
    end
    if (poke) begin
      repeat (500) @(negedge clk);
      checkOutput("no_queued_start", {30'd0, tx0, busy0}, 32'd2);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    tx_en = 1'b1;
    rx_en = 1'b1;

    checkOutput("model_par_even_01", {31'd0, correctPar(8'h01, 1)}, 1);
    checkOutput("model_par_odd_3C", {31'd0, correctPar(8'h3C, 2)}, 1);
    repeat (20) @(negedge clk);

    $display("[TB] transmit A5 with begin_flag poked while busy");
    sendTx(8'hA5, 1'b0, 1'b1);

    $display("[TB] receive 3C");
    applyStimulus(0, 8'h3C, 0, 1'b0, 1'b0);
    checkOutput("rx_3C_literal", {22'd0, rxd0, fe0, pe0}, {22'd0, 8'h3C, 2'b00});

    $display("[TB] even parity: bad then good");
    applyStimulus(1, 8'h01, 1, 1'b1, 1'b0);
    checkOutput("par_bad_literal", {23'd0, rxd1, pe1}, {23'd0, 8'h01, 1'b1});
    applyStimulus(1, 8'h01, 1, 1'b0, 1'b0);
    checkOutput("par_clear_literal", {31'd0, pe1}, 0);

    $display("[TB] framing error");
    applyStimulus(0, 8'h81, 0, 1'b0, 1'b1);
    checkOutput("fe_literal", {23'd0, rxd0, fe0}, {23'd0, 8'h81, 1'b1});

    $display("[TB] start glitch then 55");
    @(negedge clk);
    rx0 = 1'b0;
    repeat (100) @(negedge clk);
    rx0 = 1'b1;
    repeat (600) @(negedge clk);
    applyStimulus(0, 8'h55, 0, 1'b0, 1'b0);
    checkOutput("rx_55_literal", {23'd0, rxd0, fe0}, {23'd0, 8'h55, 1'b0});

    $display("[TB] rx_en drop discards partial frame");
    @(negedge clk);
    rx0 = 1'b0;
    repeat (1000) @(negedge clk);
    rx_en = 1'b0;
    repeat (10) @(negedge clk);
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    rx_en = 1'b1;
    repeat (4500) @(negedge clk);
    checkOutput("rx_en_hold_literal", {24'd0, rxd0}, 8'h55);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    tx_data    = 8'hC3;
    begin_flag = 1'b1;
    @(negedge clk);
    begin_flag = 1'b0;
    rx0 = 1'b0;
    repeat (1500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_tx", {21'd0, tx0, busy0, rxd0}, {21'd0, 2'b10, 8'h00});
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (500) @(negedge clk);
    sendTx(8'h0F, 1'b1, 1'b0);

`ifdef UART_LOOPBACK_EN
    $display("[TB] loopback 7-bit 2-stop");
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      tx_data2 = 7'h5A;
      begin2   = 1'b1;
      @(negedge clk);
      begin2 = 1'b0;
      checkOutput("lb_busy", {31'd0, busy2}, 1);
      for (int i = 0; i < 6000 && seen == 0; i++) begin
        @(negedge clk);
        if (tx2 !== 1'b1) checkOutput("lb_tx_pin", {31'd0, tx2}, 1);
        if (flag2) begin
          seen = 1;
          checkOutput("lb_rx_data", {23'd0, rxd2, fe2, pe2}, {23'd0, 7'h5A, 2'b00});
        end
      end
      checkOutput("lb_flag_seen", seen, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART: next generation of the team's fixed 8N1/115200 UART.
- Configurable clock, baud, data width, parity and stop bits.
- Receiver uses 16x oversampling with start-bit glitch rejection, and reports framing and parity errors.
- Sits between the CPU I/O register block and the board TX/RX pins; keeps the begin_flag/busy_flag/receive_flag handshake the CPU side already uses.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_en  in  1  transmitter enable.
- rx_en  in  1  receiver enable.
- begin_flag  in  1  start-transmit request, sampled each clk.
- tx_data  in  DATA_BITS  byte to send.
- rx  in  1  serial line in (asynchronous).
- tx  out  1  serial line out.
- rx_data  out  DATA_BITS  last received word.
- busy_flag  out  1  transmitter busy.
- receive_flag  out  1  one-cycle pulse: new rx_data valid.
- frame_err  out  1  stop bit sampled low in the last frame.
- parity_err  out  1  parity mismatch in the last frame; always 0 when PARITY=0.

Behaviour:
- Reset: async assert, sync-free release.
  - tx=1, busy_flag=0, rx_data=0, receive_flag=0, frame_err=0, parity_err=0.
  - Both FSMs in IDLE; all counters 0.
- Tick generator:
  - DIV = (CLK_FREQ + 8*BAUD) / (16*BAUD), integer; default 27.
  - Free-running counter 0..DIV-1; tick16 pulses one clk when it wraps.
  - Bit period = 16 ticks = 16*DIV clk (default 432).
  - Runs whenever out of reset; TX and RX share it.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if tx_en & begin_flag & !busy_flag, latch tx_data and go to START. busy_flag=1 and tx=0 from the next clk.
  - Each non-IDLE state lasts 16 tick16.
  - DATA sends DATA_BITS bits, LSB first.
  - PAR is sent only if PARITY!=0: even = XOR of data; odd = inverted XOR.
  - STOP lasts STOP_BITS*16 ticks with tx=1; then IDLE and busy_flag=0.
  - The first bit is 16*DIV minus at most DIV clk long because of tick phase; all later bits are exact.
  - begin_flag while busy: ignored, no queueing.
  - tx_en deassert mid-frame: frame completes; only new starts are blocked.
  - begin_flag in the same clk busy_flag falls: ignored. Next start is accepted one clk later.
- RX path: 2-FF synchroniser on rx. RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: synchronised falling edge with rx_en=1 goes to START and clears the tick count.
  - START: after 8 ticks, resample. If high (glitch), return to IDLE with no flag; else go to DATA.
  - DATA: sample every 16 ticks (bit centre), shift in LSB first, DATA_BITS samples.
  - PAR (if PARITY!=0): sample and compare.
  - STOP: sample the first stop bit only; low sets frame_err for this frame.
  - Completion: rx_data, frame_err and parity_err update together; receive_flag pulses 1 clk in the same cycle.
  - Error flags hold until the next completed frame.
  - A frame with errors still updates rx_data and pulses receive_flag.
  - rx_en=0: FSM forced to IDLE immediately; a partial frame is discarded with no flag, and outputs are held.
  - Return to IDLE after the stop sample (centre of stop bit), so back-to-back frames are caught.
- Width: with DATA_BITS<8, ports are DATA_BITS wide; the CPU wrapper zero-extends.

Optional Feature:
- UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the receiver input is the internal tx signal, bypassing the synchroniser. The tx pin is driven 1 (idle) while loopback=1.
- Undefined: no loopback port; the receiver always uses rx.

Test Plan:
- Defaults, tx_en=1, begin_flag pulse with tx_data=8'hA5 -> tx low for 432 clk (±27), bits 1,0,1,0,0,1,0,1, then high. busy_flag high ~4320 clk, then 0.
- Drive rx frame 8'h3C at 115200, rx_en=1 -> single receive_flag pulse, rx_data=8'h3C, frame_err=0, parity_err=0.
- PARITY=1, rx frame 8'h01 with parity bit 0 -> receive_flag, rx_data=8'h01, parity_err=1. A follow-up correct frame clears parity_err.
- rx low pulse of 100 clk, then high -> no receive_flag, FSM back to IDLE. Next valid frame 8'h55 is received correctly.
- rst_n low mid-TX and mid-RX frame -> tx=1, busy_flag=0, rx_data=0 at once. After release, the next begin_flag with 8'h0F sends a clean frame.
- UART_LOOPBACK_EN, loopback=1, DATA_BITS=7, STOP_BITS=2, send 7'h5A -> rx_data=7'h5A, receive_flag pulses, tx pin stays 1.
